// File: rtl/entry_ctrl.sv
// entry_ctrl
//   Sequencing controller for the input-unit digit shift register. Accepts one
//   decoded keypad code per valid/ready handshake and classifies it:
//     0-9 digit, A backspace, B clear, C/D operator, E decimal point, F enter.
//   Digits and the decimal point shift the register left. Backspace shifts it
//   right. Clear pulses the register's active-low reset. Operator and enter
//   keys are forwarded to the calculation unit as a one-cycle event.
//
//   Optional build macro: LEAD_ZERO_SUPPRESS_EN. When defined, a 0 typed into
//   an empty entry is consumed without shifting.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   key_valid   key code present
//   key_code    decoded key code (WIDTH bits)
//   key_ready   controller accepts a key this cycle (IDLE only)
//   sr_trig     one-cycle shift trigger pulse
//   sr_dir      0 = shift left (append), 1 = shift right (backspace)
//   sr_in       data presented to the shift register
//   sr_reset    active-low clear to the shift register
//   digit_count number of slots currently occupied
//   dp_set      decimal point present in the entry
//   full        digit_count == COUNT
//   op_valid    one-cycle operator/enter event pulse
//   op_code     key code of the event, valid with op_valid

module entry_ctrl #(
  parameter int COUNT      = 4,
  parameter int WIDTH      = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [WIDTH-1:0]           key_code,
  output logic                       key_ready,
  output logic                       sr_trig,
  output logic                       sr_dir,
  output logic [WIDTH-1:0]           sr_in,
  output logic                       sr_reset,
  output logic [$clog2(COUNT+1)-1:0] digit_count,
  output logic                       dp_set,
  output logic                       full,
  output logic                       op_valid,
  output logic [WIDTH-1:0]           op_code
);

  localparam int CW  = $clog2(COUNT+1);
  localparam int CCW = $clog2(CLR_CYCLES+1);

  localparam logic [WIDTH-1:0] KEY_DIGIT_MAX = WIDTH'(9);
  localparam logic [WIDTH-1:0] KEY_BS        = WIDTH'(10);
  localparam logic [WIDTH-1:0] KEY_CLR       = WIDTH'(11);
  localparam logic [WIDTH-1:0] KEY_OP_C      = WIDTH'(12);
  localparam logic [WIDTH-1:0] KEY_OP_D      = WIDTH'(13);
  localparam logic [WIDTH-1:0] KEY_DP        = WIDTH'(14);
  localparam logic [WIDTH-1:0] KEY_ENTER     = WIDTH'(15);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, CLEAR, EVENT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] shadow [COUNT];
  logic [CW-1:0]    count_q;
  logic             dp_q;
  logic             dir_q;
  logic [WIDTH-1:0] in_q;
  logic [CCW-1:0]   clr_cnt;

  logic             load_shift;
  logic             dir_next;
  logic [WIDTH-1:0] in_next;
  logic             is_full;
  logic             lead_zero;

  assign is_full = (count_q == CW'(COUNT));

`ifdef LEAD_ZERO_SUPPRESS_EN
  assign lead_zero = (key_code == '0) && (count_q == '0) && !dp_q;
`else
  assign lead_zero = 1'b0;
`endif

  // State register. Reset parks the FSM in CLEAR so the shift register is
  // wiped for CLR_CYCLES cycles after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + CCW'(1);
      else                clr_cnt <= '0;
    end
  end

  // Next-state decode. Keys that cannot be honoured (full entry, second
  // decimal point, backspace on empty) are consumed in IDLE with no action.
  always_comb begin
    state_next = state;
    load_shift = 1'b0;
    dir_next   = 1'b0;
    in_next    = '0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          if (key_code <= KEY_DIGIT_MAX) begin
            if (!is_full && !lead_zero) begin
              state_next = SETUP;
              load_shift = 1'b1;
              in_next    = key_code;
            end
          end else if (key_code == KEY_DP) begin
            if (!dp_q && !is_full) begin
              state_next = SETUP;
              load_shift = 1'b1;
              in_next    = key_code;
            end
          end else if (key_code == KEY_BS) begin
            if (count_q != '0) begin
              state_next = SETUP;
              load_shift = 1'b1;
              dir_next   = 1'b1;
            end
          end else if (key_code == KEY_CLR) begin
            state_next = CLEAR;
          end else if ((key_code == KEY_OP_C) || (key_code == KEY_OP_D) ||
                       (key_code == KEY_ENTER)) begin
            state_next = EVENT;
          end
        end
      end
      SETUP:   state_next = PULSE;
      PULSE:   state_next = IDLE;
      CLEAR:   if (clr_cnt == CCW'(CLR_CYCLES-1)) state_next = IDLE;
      EVENT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Entry bookkeeping. Count, decimal-point flag and shadow move on the edge
  // into PULSE so they change together with the trigger. shadow[0] is the
  // most recently entered slot, i.e. the one a backspace removes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q  <= '0;
      dir_q   <= 1'b0;
      in_q    <= '0;
      count_q <= '0;
      dp_q    <= 1'b0;
      for (int i = 0; i < COUNT; i++) shadow[i] <= '0;
    end else begin
      if ((state == IDLE) && key_valid) code_q <= key_code;
      if (load_shift) begin
        dir_q <= dir_next;
        in_q  <= in_next;
      end
      if (state == SETUP) begin
        if (!dir_q) begin
          count_q <= count_q + CW'(1);
          for (int i = COUNT-1; i > 0; i--) shadow[i] <= shadow[i-1];
          shadow[0] <= in_q;
          if (in_q == KEY_DP) dp_q <= 1'b1;
        end else begin
          count_q <= count_q - CW'(1);
          for (int i = 0; i < COUNT-1; i++) shadow[i] <= shadow[i+1];
          shadow[COUNT-1] <= '0;
          if (shadow[0] == KEY_DP) dp_q <= 1'b0;
        end
      end else if (state == CLEAR) begin
        count_q <= '0;
        dp_q    <= 1'b0;
        for (int i = 0; i < COUNT; i++) shadow[i] <= '0;
      end
    end
  end

  // Outputs decode straight from state so an asynchronous reset removes a
  // trigger or event pulse in the same cycle.
  assign key_ready   = (state == IDLE);
  assign sr_trig     = (state == PULSE);
  assign sr_reset    = (state != CLEAR);
  assign op_valid    = (state == EVENT);
  assign op_code     = (state == EVENT) ? code_q : '0;
  assign sr_dir      = dir_q;
  assign sr_in       = in_q;
  assign digit_count = count_q;
  assign dp_set      = dp_q;
  assign full        = is_full;

endmodule

// File: tb/tb_entry_ctrl.sv
// tb_entry_ctrl
//   Scoreboard bench for entry_ctrl. The driver applies keys and a reference
//   model (the entry kept as a queue of key codes) predicts the register
//   action for each accepted key. A negedge monitor pops predictions whenever
//   the DUT triggers, raises an event or finishes a clear.

module tb_entry_ctrl;

  localparam int COUNT      = 4;
  localparam int WIDTH      = 4;
  localparam int CLR_CYCLES = 2;

  localparam int K_SHIFT = 0;
  localparam int K_EVENT = 1;
  localparam int K_CLEAR = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             key_valid;
  logic [WIDTH-1:0] key_code;
  logic             key_ready;
  logic             sr_trig;
  logic             sr_dir;
  logic [WIDTH-1:0] sr_in;
  logic             sr_reset;
  logic [2:0]       digit_count;
  logic             dp_set;
  logic             full;
  logic             op_valid;
  logic [WIDTH-1:0] op_code;

  entry_ctrl #(.COUNT(COUNT), .WIDTH(WIDTH), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .sr_trig(sr_trig), .sr_dir(sr_dir), .sr_in(sr_in),
    .sr_reset(sr_reset), .digit_count(digit_count), .dp_set(dp_set),
    .full(full), .op_valid(op_valid), .op_code(op_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int kind;
    int dir;
    int data;
    int cnt;
    int dp;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   entry[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkVal(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int modelDp();
    foreach (entry[i]) if (entry[i] == 14) return 1;
    return 0;
  endfunction

  // Reference model: the entry is just the list of codes typed so far.
  task automatic modelAccept(input int code);
    exp_t e;
    e.kind = -1;
    e.dir  = 0;
    e.data = 0;
    e.cyc  = cyc;
    if (code <= 9) begin
`ifdef LEAD_ZERO_SUPPRESS_EN
      if (code == 0 && entry.size() == 0) return;
`endif
      if (entry.size() < COUNT) begin
        entry.push_back(code);
        e.kind = K_SHIFT;
        e.data = code;
      end
    end else if (code == 14) begin
      if (modelDp() == 0 && entry.size() < COUNT) begin
        entry.push_back(code);
        e.kind = K_SHIFT;
        e.data = code;
      end
    end else if (code == 10) begin
      if (entry.size() > 0) begin
        void'(entry.pop_back());
        e.kind = K_SHIFT;
        e.dir  = 1;
      end
    end else if (code == 11) begin
      entry.delete();
      e.kind = K_CLEAR;
    end else begin
      e.kind = K_EVENT;
      e.data = code;
    end
    e.cnt = entry.size();
    e.dp  = modelDp();
    if (e.kind >= 0) sb.push_back(e);
  endtask

  task automatic pushClear();
    exp_t e;
    e.kind = K_CLEAR; e.dir = 0; e.data = 0; e.cnt = 0; e.dp = 0; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic popExp(input string name, output exp_t e, output bit ok);
    e.kind = -1; e.dir = 0; e.data = 0; e.cnt = 0; e.dp = 0; e.cyc = 0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      ok = 1'b0;
      $display("[TB] FAIL unexpected_%s actual=1 required=0 (t=%0t)", name, $time);
    end else begin
      e  = sb.pop_front();
      ok = 1'b1;
    end
  endtask

  exp_t mon_e;
  bit   mon_ok;
  int   low_run = 0;

  // Monitor: compares every trigger, event and completed clear against the
  // oldest outstanding prediction.
  always @(negedge clk) begin
    if (!reset) begin
      low_run = 0;
    end else begin
      if (sr_trig) begin
        popExp("sr_trig", mon_e, mon_ok);
        if (mon_ok) begin
          checkVal("pulse_kind", K_SHIFT, mon_e.kind);
          checkVal("sr_dir", sr_dir, mon_e.dir);
          checkVal("sr_in", sr_in, mon_e.data);
          checkVal("pulse_count", digit_count, mon_e.cnt);
          checkVal("pulse_dp", dp_set, mon_e.dp);
          checkVal("pulse_latency", cyc - mon_e.cyc, 2);
        end
      end
      if (op_valid) begin
        popExp("op_valid", mon_e, mon_ok);
        if (mon_ok) begin
          checkVal("event_kind", K_EVENT, mon_e.kind);
          checkVal("op_code", op_code, mon_e.data);
          checkVal("event_count", digit_count, mon_e.cnt);
          checkVal("event_dp", dp_set, mon_e.dp);
          checkVal("event_trig", sr_trig, 0);
          checkVal("event_latency", cyc - mon_e.cyc, 1);
        end
      end
      if (!sr_reset) begin
        low_run++;
      end else if (low_run > 0) begin
        popExp("clear", mon_e, mon_ok);
        if (mon_ok) begin
          checkVal("clear_kind", K_CLEAR, mon_e.kind);
          checkVal("clear_cycles", low_run, CLR_CYCLES);
          checkVal("clear_count", digit_count, 0);
          checkVal("clear_dp", dp_set, 0);
        end
        low_run = 0;
      end
    end
  end

  task automatic applyStimulus(input int code);
    int waited;
    waited = 0;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = WIDTH'(code);
    while (!key_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!key_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL key_ready_timeout actual=0 required=1 (code=%0d)", code);
    end else begin
      modelAccept(code);
      @(posedge clk);
    end
    #1 key_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    repeat (5) @(negedge clk);
    checkVal({tag, "_sb_drained"}, sb.size(), 0);
    checkVal({tag, "_digit_count"}, digit_count, entry.size());
    checkVal({tag, "_dp_set"}, dp_set, modelDp());
    checkVal({tag, "_full"}, full, (entry.size() == COUNT) ? 1 : 0);
    checkVal({tag, "_key_ready"}, key_ready, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_key_ready"}, key_ready, 0);
    checkVal({tag, "_sr_trig"}, sr_trig, 0);
    checkVal({tag, "_sr_dir"}, sr_dir, 0);
    checkVal({tag, "_sr_in"}, sr_in, 0);
    checkVal({tag, "_sr_reset"}, sr_reset, 0);
    checkVal({tag, "_digit_count"}, digit_count, 0);
    checkVal({tag, "_dp_set"}, dp_set, 0);
    checkVal({tag, "_op_valid"}, op_valid, 0);
    checkVal({tag, "_op_code"}, op_code, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = '0;
    repeat (3) @(posedge clk);
    #1 checkResetValues("reset");
    pushClear();
    @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("post_reset");

    // Three digits append in order.
    applyStimulus(1); applyStimulus(2); applyStimulus(3);
    checkOutput("digits123");

    // Fifth digit with a four-slot register is swallowed.
    applyStimulus(11);
    applyStimulus(1); applyStimulus(2); applyStimulus(3); applyStimulus(4);
    applyStimulus(5);
    checkOutput("saturate");

    // Second decimal point ignored, backspaces remove 2 then the point.
    applyStimulus(11);
    applyStimulus(1); applyStimulus(14); applyStimulus(14); applyStimulus(2);
    checkOutput("decimal");
    applyStimulus(10); applyStimulus(10);
    checkOutput("backspace");

    // Backspace on empty, then clear after three digits.
    applyStimulus(11);
    applyStimulus(10);
    checkOutput("bs_empty");
    applyStimulus(1); applyStimulus(2); applyStimulus(3); applyStimulus(11);
    checkOutput("clear");

    // Operator and enter events leave the entry alone.
    applyStimulus(7); applyStimulus(12); applyStimulus(15); applyStimulus(13);
    checkOutput("events");

    // Leading zeros.
    applyStimulus(11);
    applyStimulus(0); applyStimulus(0); applyStimulus(7);
    checkOutput("lead_zero");

    // Randomised key stream.
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 15));
      if (i % 25 == 24) checkOutput("random");
    end
    checkOutput("random_end");

    // Asynchronous reset in the middle of a trigger pulse.
    applyStimulus(11);
    applyStimulus(5);
    @(posedge clk);
    #1 checkVal("pulse_before_reset", sr_trig, 1);
    reset = 1'b0;
    #1 checkResetValues("mid_pulse");
    checkVal("mid_pulse_full", full, 0);
    sb.delete();
    entry.delete();
    pushClear();
    @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("after_abort");
    applyStimulus(9);
    checkOutput("after_abort_digit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/entry_ctrl.md
Name: entry_ctrl

Overview:
Sequencing controller for the input-unit digit shift register. It accepts one decoded keypad code per handshake and classifies it as digit, decimal point, backspace, clear, operator or enter. It drives the register's trigger, direction, data and clear lines, tracks entry length, and forwards operator/enter events to the calculation unit.

Parameters:
COUNT, 4, digit slots in the shift register
WIDTH, 4, bits per slot and per key code (fixed 4 for code map)
CLR_CYCLES, 2, cycles sr_reset held low on clear

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
key_valid  input  1  key code present
key_code  input  WIDTH  0-9 digit, A backspace, B clear, C/D operator, E decimal point, F enter
key_ready  output  1  controller accepts key this cycle
sr_trig  output  1  shift-register trigger, one-cycle high pulse
sr_dir  output  1  0 = left (append), 1 = right (backspace)
sr_in  output  WIDTH  data presented to shift register
sr_reset  output  1  active-low clear to shift register
digit_count  output  $clog2(COUNT+1)  digits currently held
dp_set  output  1  decimal point present in entry
full  output  1  digit_count == COUNT
op_valid  output  1  one-cycle pulse, operator/enter event
op_code  output  WIDTH  key code of event, valid with op_valid

Behaviour:
- Clock domain: single clk. Reset is asynchronous and active-low. Reset values: key_ready=0, sr_trig=0, sr_dir=0, sr_in=0, sr_reset=0, digit_count=0, dp_set=0, op_valid=0, op_code=0. FSM enters CLEAR on reset release.
- Handshake: a key is accepted when key_valid and key_ready are both high in the same cycle. key_ready is high only in IDLE. Accepted code is latched. No new key is accepted until the FSM returns to IDLE.
- FSM states: IDLE, SETUP, PULSE, CLEAR, EVENT.
- IDLE, digit, not full: go to SETUP with sr_dir=0, sr_in=code.
- IDLE, digit, full: key is consumed and ignored; stay in IDLE.
- IDLE, code E, dp_set=0 and count<COUNT: go to SETUP with sr_dir=0, sr_in=E, then set dp_set.
- IDLE, code E, dp_set=1 or full: ignored.
- IDLE, code A, count>0: go to SETUP with sr_dir=1, sr_in=0.
  - If the slot removed is the decimal point, clear dp_set. The controller keeps a COUNT-deep shadow of codes to know this.
- IDLE, code A, count=0: ignored.
- IDLE, code B: go to CLEAR.
- IDLE, codes C/D/F: go to EVENT.
- SETUP: sr_dir and sr_in are stable; sr_trig=0. Next state is PULSE. This gives one cycle of setup before the edge.
- PULSE: sr_trig=1 for exactly one cycle. digit_count increments (left) or decrements (right) in this same cycle. Return to IDLE. sr_dir/sr_in hold until the next SETUP.
- CLEAR: sr_reset=0 for CLR_CYCLES cycles; digit_count, dp_set and shadow are zeroed. Return to IDLE with sr_reset=1.
- EVENT: op_valid=1 and op_code=code for one cycle. Entry is not cleared (clearing is the calculation unit's job via code B). Return to IDLE.
- Latency from accept to sr_trig rising edge: 2 cycles. Accept-to-accept minimum is 3 cycles for a shift, CLR_CYCLES+1 for a clear, and 2 for an event.
- full is combinational from digit_count. The decimal point occupies a slot and counts toward full.
- Reset mid-operation: an asserted reset aborts any state immediately. sr_trig is forced low with no partial pulse, and sr_reset is driven low.
- digit_count never wraps. Saturation is enforced by the ignore rules above.

Optional Feature:
LEAD_ZERO_SUPPRESS_EN: when defined, digit 0 accepted while digit_count==0 and dp_set==0 is consumed without a shift, so count stays 0. When undefined, a leading 0 shifts in like any digit.

Test Plan:
- Reset low then high; keys 1,2,3 -> three sr_trig pulses, sr_dir=0, sr_in=1,2,3, each pulse 2 cycles after its accept; digit_count=3.
- Keys 1,2,3,4,5 with COUNT=4 -> exactly 4 pulses; full=1 after 4th; key 5 accepted with no pulse and count stays 4.
- Keys 1,E,E,2 -> pulses for 1,E,2 only; dp_set=1; key A twice -> two right pulses with sr_in=0; dp_set clears on second A; count=1.
- Key A at count=0 -> no pulse; key B after 3 digits -> sr_reset low for 2 cycles, count=0, dp_set=0.
- Key C then F -> op_valid pulses with op_code=C then F, no sr_trig, count unchanged; reset asserted during PULSE -> sr_trig low same cycle, all outputs at reset values.
- With LEAD_ZERO_SUPPRESS_EN, keys 0,0,7 -> single pulse (7), count=1; without the macro -> 3 pulses, count=3.
